// File: rtl/apb_i2c_master.sv
// rtl/apb_i2c_master.sv - APB-programmed I2C master moving one byte per transaction
// Open-drain sda/scl: the block only ever pulls low or releases.
module apb_i2c_master #(
  parameter logic [7:0] PRESCALE_RST = 8'd4
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       PSELx,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic       PREADY,
  output logic [7:0] PRDATA,
  inout  wire        sda,
  inout  wire        scl
);
  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, MACK, STOP
  } state_t;

  state_t     state;
  logic [7:0] prescale, slave, txdata, rxdata;
  logic       busy, done, nack;
  logic [7:0] presc_act, cnt;
  logic [1:0] q;
  logic [2:0] bit_idx;
  logic [7:0] addr_byte, data_byte, rx_shift;
  logic       ack_in;
  logic       sda_low, scl_low;

  logic access, wr_en, go, tick, bit_end, sda_in;

  assign access  = PSELx & PENABLE & ~PRESET;
  assign wr_en   = PSELx & PENABLE & PWRITE;
  assign go      = wr_en && (PADDR == 8'h10) && PWDATA[0] && (state == IDLE);
  assign tick    = (state != IDLE) && (cnt == presc_act);
  assign bit_end = tick && (q == 2'd3);
  assign sda_in  = sda;

  assign PREADY = access;
  assign sda    = sda_low ? 1'b0 : 1'bz;
  assign scl    = scl_low ? 1'b0 : 1'bz;

  always_comb begin
    PRDATA = 8'h00;
    if (access && !PWRITE) begin
      case (PADDR)
        8'h00:   PRDATA = prescale;
        8'h04:   PRDATA = slave;
        8'h08:   PRDATA = txdata;
        8'h0C:   PRDATA = rxdata;
        8'h14:   PRDATA = {5'b0, nack, done, busy};
        default: PRDATA = 8'h00;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      prescale  <= PRESCALE_RST;
      slave     <= 8'h00;
      txdata    <= 8'h00;
      rxdata    <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
      state     <= IDLE;
      cnt       <= 8'h00;
      presc_act <= PRESCALE_RST;
      q         <= 2'd0;
      bit_idx   <= 3'd0;
      addr_byte <= 8'h00;
      data_byte <= 8'h00;
      rx_shift  <= 8'h00;
      ack_in    <= 1'b1;
      sda_low   <= 1'b0;
      scl_low   <= 1'b0;
    end else begin
      if (wr_en) begin
        case (PADDR)
          8'h00:   prescale <= PWDATA;
          8'h04:   slave    <= PWDATA;
          8'h08:   txdata   <= PWDATA;
          default: ;
        endcase
      end

      if (state != IDLE) cnt <= tick ? 8'h00 : cnt + 8'd1;
      // The active divider is reloaded only on tick boundaries so a mid-transfer
      // PRESCALE write never shortens or stretches the quarter already running.
      if (tick) begin
        q         <= q + 2'd1;
        presc_act <= prescale;
      end

      if (tick && q == 2'd2) begin
        ack_in <= sda_in;
        if (state == RDATA) rx_shift <= {rx_shift[6:0], sda_in};
      end

      case (state)
        IDLE: if (go) begin
          state     <= START;
          busy      <= 1'b1;
          done      <= 1'b0;
          nack      <= 1'b0;
          addr_byte <= slave;
          data_byte <= txdata;
          cnt       <= 8'h00;
          q         <= 2'd0;
          presc_act <= prescale;
        end
        START: if (bit_end) begin
          state   <= ADDR;
          bit_idx <= 3'd7;
        end
        ADDR: if (bit_end) begin
          if (bit_idx == 3'd0) state <= ADDR_ACK;
          else bit_idx <= bit_idx - 3'd1;
        end
        ADDR_ACK: if (bit_end) begin
          bit_idx <= 3'd7;
          if (ack_in) begin
            nack  <= 1'b1;
            state <= STOP;
          end else if (addr_byte[0]) state <= RDATA;
          else state <= WDATA;
        end
        WDATA: if (bit_end) begin
          if (bit_idx == 3'd0) state <= WACK;
          else bit_idx <= bit_idx - 3'd1;
        end
        WACK: if (bit_end) begin
          if (ack_in) nack <= 1'b1;
          state <= STOP;
        end
        RDATA: if (bit_end) begin
          if (bit_idx == 3'd0) begin
            rxdata <= rx_shift;
            state  <= MACK;
          end else bit_idx <= bit_idx - 3'd1;
        end
        MACK: if (bit_end) state <= STOP;
        STOP: if (bit_end) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // Pin drivers follow the current state/quarter one cycle later.
      scl_low <= 1'b0;
      sda_low <= 1'b0;
      case (state)
        START: sda_low <= q[1];
        ADDR: begin
          scl_low <= ~q[1];
          sda_low <= ~addr_byte[bit_idx];
        end
        WDATA: begin
          scl_low <= ~q[1];
          sda_low <= ~data_byte[bit_idx];
        end
        ADDR_ACK, WACK, RDATA, MACK: scl_low <= ~q[1];
        STOP: begin
          scl_low <= (q == 2'd0);
          sda_low <= ~q[1];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_i2c_master.sv
// tb/tb_apb_i2c_master.sv - directed scoreboard bench for apb_i2c_master
// A bus monitor/slave logs START, 9-bit frames {byte, ack} and STOP; expectations queue up front.
module tb_apb_i2c_master;
  localparam int START_EV = 1000;
  localparam int STOP_EV  = 1001;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       PSELx = 1'b0;
  logic       PENABLE = 1'b0;
  logic       PWRITE = 1'b0;
  logic [7:0] PADDR = 8'h00;
  logic [7:0] PWDATA = 8'h00;
  logic       PREADY;
  logic [7:0] PRDATA;
  wire        sda;
  wire        scl;

  pullup (sda);
  pullup (scl);

  logic slave_low = 1'b0;
  assign sda = slave_low ? 1'b0 : 1'bz;

  apb_i2c_master #(.PRESCALE_RST(8'd4)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSELx(PSELx), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY),
    .PRDATA(PRDATA), .sda(sda), .scl(scl)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int obs[$];
  int rise_t[$];
  int rd_idx = 0;

  logic       ack_addr = 1'b1;
  logic       ack_data = 1'b1;
  logic [7:0] rd_byte = 8'h00;

  int         cyc = 0;
  logic       sda_p = 1'b1, scl_p = 1'b1, rst_p = 1'b1;
  logic [8:0] frame = 9'h000;
  int         bidx = 0, byidx = 0;
  logic       rd_mode = 1'b0;

  always begin
    @(negedge PCLK);
    #1;
    cyc++;
    if (PRESET || rst_p) begin
      bidx = 0;
      byidx = 0;
      slave_low = 1'b0;
    end else if (scl_p && scl && sda_p && !sda) begin
      obs.push_back(START_EV);
      bidx = 0;
      byidx = 0;
    end else if (scl_p && scl && !sda_p && sda) begin
      obs.push_back(STOP_EV);
      slave_low = 1'b0;
    end else if (!scl_p && scl) begin
      rise_t.push_back(cyc);
      frame = {frame[7:0], sda};
      bidx++;
      if (bidx == 9) begin
        obs.push_back(int'(frame));
        if (byidx == 0) rd_mode = frame[1];
        byidx++;
        bidx = 0;
      end
    end else if (scl_p && !scl) begin
      if (byidx == 0 && bidx == 8) slave_low = ack_addr;
      else if (byidx == 1 && rd_mode && bidx < 8) slave_low = ~rd_byte[7 - bidx];
      else if (byidx == 1 && !rd_mode && bidx == 8) slave_low = ack_data;
      else slave_low = 1'b0;
    end
    rst_p = PRESET;
    sda_p = sda;
    scl_p = scl;
  end

  task automatic check(input string tag, input int o, input int e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge PCLK);
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 check("pready_wr", int'(PREADY), 1);
    @(negedge PCLK);
    PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge PCLK);
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    d = PRDATA;
    check("pready_rd", int'(PREADY), 1);
    @(negedge PCLK);
    PSELx = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] e);
    logic [7:0] d;
    apb_read(a, d);
    check(tag, int'(d), int'(e));
  endtask

  task automatic wait_idle();
    logic [7:0] s;
    int n = 0;
    do begin
      apb_read(8'h14, s);
      n++;
    end while (s[0] && n < 600);
    check("idle_reached", int'(s[0]), 0);
  endtask

  task automatic drain();
    int e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (rd_idx < obs.size()) ? obs[rd_idx] : -1;
      rd_idx++;
      check("bus_event", o, e);
    end
    check("bus_event_count", obs.size(), rd_idx);
    rd_idx = obs.size();
  endtask

  function automatic int period(input int base);
    if (rise_t.size() > base + 1) return rise_t[base + 1] - rise_t[base];
    return -1;
  endfunction

  int base;

  initial begin
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    #1;
    check("pready_idle", int'(PREADY), 0);
    check("prdata_idle", int'(PRDATA), 0);
    check("sda_idle", int'(sda), 1);
    check("scl_idle", int'(scl), 1);
    read_check("rst_status", 8'h14, 8'h00);
    read_check("rst_prescale", 8'h00, 8'h04);
    read_check("rst_slave", 8'h04, 8'h00);
    read_check("rst_txdata", 8'h08, 8'h00);
    read_check("rst_rxdata", 8'h0C, 8'h00);
    read_check("ctrl_reads_zero", 8'h10, 8'h00);
    apb_write(8'h0C, 8'h55);
    read_check("rxdata_ro", 8'h0C, 8'h00);
    apb_write(8'h14, 8'hFF);
    read_check("status_ro", 8'h14, 8'h00);
    apb_write(8'h20, 8'h77);
    read_check("unmapped_rd", 8'h20, 8'h00);

    // write 0x5A to 0x50 (0xA0 write), both bytes acked
    apb_write(8'h00, 8'h04);
    apb_write(8'h04, 8'hA0);
    apb_write(8'h08, 8'h5A);
    read_check("slave_rw", 8'h04, 8'hA0);
    ack_addr = 1'b1; ack_data = 1'b1;
    exp_q.push_back(START_EV); exp_q.push_back(9'h140);
    exp_q.push_back(9'h0B4);   exp_q.push_back(STOP_EV);
    base = rise_t.size();
    apb_write(8'h10, 8'h01);
    wait_idle();
    read_check("wr_status", 8'h14, 8'h02);
    check("bit_period_p4", period(base), 20);
    drain();

    // read one byte, slave returns 0xC3, master NACKs
    apb_write(8'h04, 8'hA1);
    rd_byte = 8'hC3;
    exp_q.push_back(START_EV); exp_q.push_back(9'h142);
    exp_q.push_back(9'h187);   exp_q.push_back(STOP_EV);
    apb_write(8'h10, 8'h01);
    wait_idle();
    read_check("rd_rxdata", 8'h0C, 8'hC3);
    read_check("rd_status", 8'h14, 8'h02);
    drain();

    // address NACK at a faster prescale
    apb_write(8'h00, 8'h02);
    read_check("prescale_rw", 8'h00, 8'h02);
    apb_write(8'h04, 8'h90);
    ack_addr = 1'b0;
    exp_q.push_back(START_EV); exp_q.push_back(9'h121); exp_q.push_back(STOP_EV);
    base = rise_t.size();
    apb_write(8'h10, 8'h01);
    wait_idle();
    read_check("nack_status", 8'h14, 8'h06);
    check("bit_period_p2", period(base), 12);
    drain();

    // busy protection: second GO and TXDATA change must not affect the bus
    ack_addr = 1'b1;
    apb_write(8'h04, 8'hA0);
    apb_write(8'h08, 8'h3C);
    exp_q.push_back(START_EV); exp_q.push_back(9'h140);
    exp_q.push_back(9'h078);   exp_q.push_back(STOP_EV);
    apb_write(8'h10, 8'h01);
    repeat (60) @(negedge PCLK);
    apb_write(8'h08, 8'hFF);
    apb_write(8'h10, 8'h01);
    read_check("busy_status", 8'h14, 8'h01);
    read_check("unmapped_busy", 8'h20, 8'h00);
    wait_idle();
    read_check("busy_done_status", 8'h14, 8'h02);
    read_check("txdata_rw", 8'h08, 8'hFF);
    drain();

    // reset in the middle of the address byte
    apb_write(8'h00, 8'h07);
    apb_write(8'h04, 8'hA0);
    exp_q.push_back(START_EV);
    apb_write(8'h10, 8'h01);
    repeat (60) @(negedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b1; PSELx = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 8'h14;
    #1;
    check("pready_in_reset", int'(PREADY), 0);
    check("prdata_in_reset", int'(PRDATA), 0);
    @(negedge PCLK);
    PRESET = 1'b0; PSELx = 1'b0; PENABLE = 1'b0;
    #1;
    check("sda_after_rst", int'(sda), 1);
    check("scl_after_rst", int'(scl), 1);
    read_check("rst_mid_status", 8'h14, 8'h00);
    read_check("rst_mid_prescale", 8'h00, 8'h04);
    repeat (200) @(negedge PCLK);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
